// File: rtl/proc_proc_oci_dct_packer_pkg.sv
// Shared definitions for the OCI DCT trace packer: widths, packed word layout,
// atom codes and the accumulator/output-register state encodings.
package proc_proc_oci_pkg;

   localparam int ATOM_W         = 3;
   localparam int ATOMS_PER_WORD = 10;
   localparam int BUF_W          = ATOM_W * ATOMS_PER_WORD;
   localparam int CNT_W          = 4;

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ATOMS_PER_WORD);

   localparam logic [ATOM_W-1:0] NT   = 3'b000;
   localparam logic [ATOM_W-1:0] TK   = 3'b001;
   localparam logic [ATOM_W-1:0] IND  = 3'b010;
   localparam logic [ATOM_W-1:0] EXC  = 3'b011;
   localparam logic [ATOM_W-1:0] SYNC = 3'b111;

   typedef struct packed {
      logic [CNT_W-1:0] count;
      logic [BUF_W-1:0] buffer;
   } dct_word_t;

   typedef enum logic [1:0] {
      ACC_EMPTY   = 2'd0,
      ACC_FILLING = 2'd1,
      ACC_FULL    = 2'd2
   } acc_state_e;

   typedef enum logic {
      OUT_IDLE = 1'b0,
      OUT_HOLD = 1'b1
   } out_state_e;

   // Accumulator state is a pure decode of the fill count.
   function automatic acc_state_e acc_state_of(input logic [CNT_W-1:0] cnt);
      if (cnt == CNT_ZERO) begin
         return ACC_EMPTY;
      end else if (cnt >= CNT_FULL) begin
         return ACC_FULL;
      end else begin
         return ACC_FILLING;
      end
   endfunction

endpackage

// File: rtl/proc_proc_oci_dct_packer_outreg.sv
// One-entry valid/ready holding register between the DCT accumulator and the
// trace FIFO. Accepts a new word in the same cycle the held word drains.
module proc_proc_oci_dct_outreg
   import proc_proc_oci_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      in_valid,
   input  dct_word_t in_word,
   output logic      in_ready,
   output logic      out_valid,
   input  logic      out_ready,
   output dct_word_t out_word
);

   out_state_e st_r;
   out_state_e st_s;
   dct_word_t  word_r;
   dct_word_t  word_s;

   assign in_ready  = (st_r == OUT_IDLE) | out_ready;
   assign out_valid = (st_r == OUT_HOLD);
   assign out_word  = word_r;

   // Next-state and next-word selection for the holding register.
   always_comb begin
      st_s   = st_r;
      word_s = word_r;
      case (st_r)
         OUT_IDLE: begin
            if (in_valid) begin
               st_s   = OUT_HOLD;
               word_s = in_word;
            end else begin
               st_s   = OUT_IDLE;
            end
         end
         OUT_HOLD: begin
            if (out_ready) begin
               if (in_valid) begin
                  st_s   = OUT_HOLD;
                  word_s = in_word;
               end else begin
                  st_s   = OUT_IDLE;
                  word_s = '0;
               end
            end else begin
               st_s   = OUT_HOLD;
            end
         end
         default: begin
            st_s   = OUT_IDLE;
            word_s = '0;
         end
      endcase
   end

   // State and data register; the held word stays frozen while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         st_r   <= OUT_IDLE;
         word_r <= '0;
      end else begin
         st_r   <= st_s;
         word_r <= word_s;
      end
   end

endmodule

// File: rtl/proc_proc_oci_dct_packer.sv
// Packs 3-bit DCT trace atoms into 30-bit words with a fill count and hands them
// to the trace FIFO. Optional drop counter enabled by PROC_OCI_DCT_OVF_CNT_EN.
module proc_proc_oci_dct_packer
   import proc_proc_oci_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   trace_en,
   input  logic                   atom_valid,
   input  logic [ATOM_W-1:0]      atom,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CNT_W+BUF_W-1:0] out_data,
   output logic [BUF_W-1:0]       dct_buffer,
   output logic [CNT_W-1:0]       dct_count,
   output logic                   atom_drop,
   output logic [7:0]             ovf_count
);

   logic [BUF_W-1:0] buf_r;
   logic [BUF_W-1:0] buf_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   acc_state_e       st_r;
   acc_state_e       st_s;
   logic             flush_pend_r;
   logic             flush_pend_s;
   logic             atom_drop_r;
   logic             drop_s;
   logic             xfer_s;
   dct_word_t        xfer_word_s;
   dct_word_t        out_word_s;
   logic             in_ready_s;
   logic             acc_in_s;
   logic             flush_req_s;
   logic [BUF_W-1:0] pk_buf_s;
   logic [CNT_W-1:0] pk_cnt_s;

   assign acc_in_s    = atom_valid & trace_en;
   assign flush_req_s = flush | flush_pend_r;
   // Candidate accumulator contents once this cycle's atom (if any) is packed.
   assign pk_buf_s    = acc_in_s ? {buf_r[BUF_W-ATOM_W-1:0], atom} : buf_r;
   assign pk_cnt_s    = acc_in_s ? (cnt_r + CNT_ONE) : cnt_r;

   // Accumulator next state: pack, complete, flush, or drop.
   always_comb begin
      buf_s        = buf_r;
      cnt_s        = cnt_r;
      flush_pend_s = flush_pend_r;
      drop_s       = 1'b0;
      xfer_s       = 1'b0;
      xfer_word_s  = '0;
      case (st_r)
         ACC_FULL: begin
            if (in_ready_s) begin
               xfer_s       = 1'b1;
               xfer_word_s  = '{count: cnt_r, buffer: buf_r};
               flush_pend_s = 1'b0;
               if (acc_in_s) begin
                  buf_s = {{(BUF_W-ATOM_W){1'b0}}, atom};
                  cnt_s = CNT_ONE;
               end else begin
                  buf_s = '0;
                  cnt_s = CNT_ZERO;
               end
            end else begin
               drop_s = acc_in_s;
            end
         end
         ACC_EMPTY, ACC_FILLING: begin
            if (flush_req_s && (pk_cnt_s != CNT_ZERO)) begin
               if (in_ready_s) begin
                  xfer_s       = 1'b1;
                  xfer_word_s  = '{count: pk_cnt_s, buffer: pk_buf_s};
                  buf_s        = '0;
                  cnt_s        = CNT_ZERO;
                  flush_pend_s = 1'b0;
               end else begin
                  buf_s        = pk_buf_s;
                  cnt_s        = pk_cnt_s;
                  flush_pend_s = 1'b1;
               end
            end else begin
               buf_s        = pk_buf_s;
               cnt_s        = pk_cnt_s;
               flush_pend_s = 1'b0;
            end
         end
         default: begin
            buf_s        = '0;
            cnt_s        = CNT_ZERO;
            flush_pend_s = 1'b0;
         end
      endcase
      st_s = acc_state_of(cnt_s);
   end

   // Accumulator, pending-flush and drop-pulse registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_r        <= '0;
         cnt_r        <= CNT_ZERO;
         st_r         <= ACC_EMPTY;
         flush_pend_r <= 1'b0;
         atom_drop_r  <= 1'b0;
      end else begin
         buf_r        <= buf_s;
         cnt_r        <= cnt_s;
         st_r         <= st_s;
         flush_pend_r <= flush_pend_s;
         atom_drop_r  <= drop_s;
      end
   end

   proc_proc_oci_dct_outreg u_outreg (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (xfer_s),
      .in_word   (xfer_word_s),
      .in_ready  (in_ready_s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word_s)
   );

   assign out_data   = out_word_s;
   assign dct_buffer = buf_r;
   assign dct_count  = cnt_r;
   assign atom_drop  = atom_drop_r;

`ifdef PROC_OCI_DCT_OVF_CNT_EN
   logic [7:0] ovf_r;

   // Saturating count of dropped atoms, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_r <= 8'd0;
      end else if (drop_s && (ovf_r != 8'hFF)) begin
         ovf_r <= ovf_r + 8'd1;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign ovf_count = ovf_r;
`else
   assign ovf_count = 8'd0;
`endif

endmodule

// File: tb/tb_proc_proc_oci_dct_packer.sv
// Scoreboard bench for the DCT packer: expected words are queued as atoms are
// driven and compared when the packer hands a word to the sink.
module tb_proc_proc_oci_dct_packer;
   import proc_proc_oci_pkg::*;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   trace_en;
   logic                   atom_valid;
   logic [ATOM_W-1:0]      atom;
   logic                   flush;
   logic                   out_valid;
   logic                   out_ready;
   logic [CNT_W+BUF_W-1:0] out_data;
   logic [BUF_W-1:0]       dct_buffer;
   logic [CNT_W-1:0]       dct_count;
   logic                   atom_drop;
   logic [7:0]             ovf_count;

`ifdef PROC_OCI_DCT_OVF_CNT_EN
   localparam logic [7:0] OVF_AFTER_DROP = 8'd1;
`else
   localparam logic [7:0] OVF_AFTER_DROP = 8'd0;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [CNT_W+BUF_W-1:0] exp_q[$];
   logic [BUF_W-1:0] mb;
   logic [CNT_W-1:0] mc;

   proc_proc_oci_dct_packer dut (
      .clk        (clk),
      .reset      (reset),
      .trace_en   (trace_en),
      .atom_valid (atom_valid),
      .atom       (atom),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .dct_buffer (dct_buffer),
      .dct_count  (dct_count),
      .atom_drop  (atom_drop),
      .ovf_count  (ovf_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Hold the given inputs across one rising edge, then return to idle.
   task automatic step(input logic v, input logic [ATOM_W-1:0] a, input logic f);
      atom_valid = v;
      atom       = a;
      flush      = f;
      @(posedge clk);
      #1;
      atom_valid = 1'b0;
      atom       = '0;
      flush      = 1'b0;
   endtask

   task automatic model_pack(input logic [ATOM_W-1:0] a);
      mb = {mb[BUF_W-ATOM_W-1:0], a};
      mc = mc + 4'd1;
      if (mc == 4'd10) begin
         exp_q.push_back({mc, mb});
         mb = '0;
         mc = 4'd0;
      end
   endtask

   task automatic model_flush();
      if (mc != 4'd0) begin
         exp_q.push_back({mc, mb});
         mb = '0;
         mc = 4'd0;
      end
   endtask

   task automatic feed(input logic [ATOM_W-1:0] a);
      step(1'b1, a, 1'b0);
      model_pack(a);
   endtask

   task automatic feed_flush(input logic [ATOM_W-1:0] a);
      step(1'b1, a, 1'b1);
      model_pack(a);
      model_flush();
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         step(1'b0, NT, 1'b0);
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_out_data"}, 64'(out_data), 64'd0);
      chk({tag, "_dct_buffer"}, 64'(dct_buffer), 64'd0);
      chk({tag, "_dct_count"}, 64'(dct_count), 64'd0);
      chk({tag, "_atom_drop"}, 64'(atom_drop), 64'd0);
      chk({tag, "_ovf_count"}, 64'(ovf_count), 64'd0);
   endtask

   // Sink side: every handshake must match the oldest queued word.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            chk("word", 64'(out_data), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      logic [ATOM_W-1:0] a;
      reset      = 1'b1;
      trace_en   = 1'b1;
      atom_valid = 1'b0;
      atom       = '0;
      flush      = 1'b0;
      out_ready  = 1'b1;
      mb         = '0;
      mc         = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset = 1'b0;

      // Ten TK/IND atoms form one full word.
      for (int i = 0; i < 10; i++) begin
         feed((i % 2 == 0) ? TK : IND);
      end
      chk("full_count", 64'(dct_count), 64'd10);
      chk("full_buffer", 64'(dct_buffer), 64'h0A28_A28A);
      chk("full_not_yet_valid", 64'(out_valid), 64'd0);
      step(1'b0, NT, 1'b0);
      chk("full_valid", 64'(out_valid), 64'd1);
      chk("full_count_clear", 64'(dct_count), 64'd0);
      step(1'b0, NT, 1'b0);
      chk("full_valid_one_cycle", 64'(out_valid), 64'd0);

      // Partial word via flush, then a flush with nothing to emit.
      feed(TK);
      feed(IND);
      feed(EXC);
      chk("partial_buffer", 64'(dct_buffer), 64'h53);
      step(1'b0, NT, 1'b1);
      model_flush();
      chk("flush_valid", 64'(out_valid), 64'd1);
      chk("flush_data", 64'(out_data), {30'd0, 4'd3, 30'h0000_0053});
      step(1'b0, NT, 1'b0);
      step(1'b0, NT, 1'b1);
      step(1'b0, NT, 1'b0);
      chk("empty_flush_no_word", 64'(out_valid), 64'd0);

      // Sink stalled: one word held, accumulator full, then drops.
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         a = 3'(i);
         feed(a);
      end
      chk("stall_count", 64'(dct_count), 64'd10);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_hold_data", 64'(out_data), 64'(exp_q[0]));
      chk("stall_ovf_before", 64'(ovf_count), 64'd0);
      step(1'b1, SYNC, 1'b0);
      chk("drop_pulse", 64'(atom_drop), 64'd1);
      chk("drop_count_kept", 64'(dct_count), 64'd10);
      chk("drop_ovf", 64'(ovf_count), 64'(OVF_AFTER_DROP));
      step(1'b0, NT, 1'b0);
      chk("drop_pulse_end", 64'(atom_drop), 64'd0);
      chk("stall_hold_data2", 64'(out_data), 64'(exp_q[0]));
      out_ready = 1'b1;
      drain();

      // Atom arriving with the full-word transfer, then atom+flush at count 4.
      for (int i = 0; i < 11; i++) begin
         a = 3'(i % 5);
         feed(a);
      end
      chk("nobubble_count", 64'(dct_count), 64'd1);
      chk("nobubble_buffer", 64'(dct_buffer), 64'(mb));
      feed(SYNC);
      feed(TK);
      feed(EXC);
      chk("pre_af_count", 64'(dct_count), 64'd4);
      feed_flush(IND);
      chk("af_count_clear", 64'(dct_count), 64'd0);
      chk("af_valid", 64'(out_valid), 64'd1);
      drain();

      // Flush while blocked remains pending until the sink frees up.
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         a = 3'((i * 3) % 8);
         feed(a);
      end
      step(1'b0, NT, 1'b1);
      chk("pend_count", 64'(dct_count), 64'd2);
      feed(EXC);
      chk("pend_count2", 64'(dct_count), 64'd3);
      model_flush();
      out_ready = 1'b1;
      drain();
      chk("pend_count_clear", 64'(dct_count), 64'd0);

      // Reset with a partial word and a held word discards both.
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, TK, 1'b0);
      end
      chk("prerst_count", 64'(dct_count), 64'd6);
      chk("prerst_valid", 64'(out_valid), 64'd1);
      reset = 1'b1;
      step(1'b0, NT, 1'b0);
      chk_all_zero("midrst");
      reset     = 1'b0;
      out_ready = 1'b1;
      repeat (4) step(1'b0, NT, 1'b0);
      chk("postrst_no_word", 64'(out_valid), 64'd0);

      // Atoms with trace disabled are ignored, not dropped.
      trace_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, IND, 1'b0);
         chk("trace_off_count", 64'(dct_count), 64'd0);
         chk("trace_off_drop", 64'(atom_drop), 64'd0);
      end
      trace_en = 1'b1;

      chk("final_queue", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
